// File: rtl/cdb_arbiter_if.sv
// Result-bus bundle between the producer channels, the CDB arbiter and the
// broadcast consumers. The master side drives results; the slave side
// (the arbiter) returns grants and the registered broadcast.
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 6,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      cdb_valid;
  logic [DATA_W-1:0]         cdb_data;
  logic [TAG_W-1:0]          cdb_tag;
  logic [SRC_W-1:0]          cdb_src;
  logic [15:0]               stall_cnt;

  modport master (
    output src_valid, src_data, src_tag,
    input  src_ready, cdb_valid, cdb_data, cdb_tag, cdb_src, stall_cnt
  );

  modport slave (
    input  src_valid, src_data, src_tag,
    output src_ready, cdb_valid, cdb_data, cdb_tag, cdb_src, stall_cnt
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one producer channel per cycle, broadcasts
// its data/tag/index from a single output register one cycle after accept,
// and counts contended cycles in a saturating 16-bit counter.
// Build option: define CDB_RR_EN for round-robin arbitration; without it the
// lowest valid channel index always wins (fixed priority).
module cdb_arbiter #(
  parameter int NUM_SRC = 6,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               contended;

`ifdef CDB_RR_EN
  logic [SRC_W-1:0] rr_ptr;

  // Round-robin search starting at rr_ptr, first valid channel wins.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!grant_any && bus.src_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = SRC_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

  // Pointer moves past the winner on each grant and holds otherwise.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_any && bus.src_valid[k]) begin
        grant[k]  = 1'b1;
        grant_idx = SRC_W'(k);
        grant_any = 1'b1;
      end
    end
  end
`endif

  // More than one requester means at least one valid channel goes ungranted.
  assign contended = (bus.src_valid & (bus.src_valid - 1'b1)) != '0;

  // Nothing is accepted while reset is held.
  assign bus.src_ready = rst ? '0 : grant;

  // Single broadcast register: loaded on a grant, zeroed in idle cycles.
  always_ff @(posedge clk) begin
    if (rst || !grant_any) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_data  <= '0;
      bus.cdb_tag   <= '0;
      bus.cdb_src   <= '0;
    end else begin
      bus.cdb_valid <= 1'b1;
      bus.cdb_data  <= bus.src_data[grant_idx*DATA_W +: DATA_W];
      bus.cdb_tag   <= bus.src_tag[grant_idx*TAG_W +: TAG_W];
      bus.cdb_src   <= grant_idx;
    end
  end

  // Saturating count of contended cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stall_cnt <= '0;
    end else if (contended && bus.stall_cnt != 16'hFFFF) begin
      bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter. A table of per-cycle vectors drives
// requests with expected grants for both arbitration builds; a scoreboard
// queue holds the broadcast expected one cycle later. A long contended run
// exercises stall counter saturation.
module tb_cdb_arbiter;
  localparam int NUM_SRC = 6;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int SRC_W   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  cdb_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic [5:0] valid;
    int         exp_rr;
    int         exp_fp;
  } vec_t;

  typedef struct {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [SRC_W-1:0]  src;
  } cdb_t;

  cdb_t              sb_q[$];
  int                checks   = 0;
  int                failures = 0;
  logic [DATA_W-1:0] ch_data[NUM_SRC];
  logic [TAG_W-1:0]  ch_tag[NUM_SRC];
  int                m_ptr;
  int                m_stall;
  vec_t              vecs[23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference grant for cycles not covered by the hand-derived table.
  function automatic int model_grant(input logic [5:0] v);
    int g;
    g = -1;
`ifdef CDB_RR_EN
    for (int k = 0; k < NUM_SRC; k++)
      if (g < 0 && v[(m_ptr + k) % NUM_SRC]) g = (m_ptr + k) % NUM_SRC;
`else
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (v[k]) g = k;
`endif
    return g;
  endfunction

  // One clock cycle: drive, compare mid-cycle, update model at the edge.
  // exp = -2 asks the reference model for the grant.
  task automatic step(input logic r, input logic [5:0] v, input int exp);
    int   g;
    cdb_t e;
    rst           = r;
    bus.src_valid = v;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_data[i*DATA_W +: DATA_W] = ch_data[i];
      bus.src_tag[i*TAG_W +: TAG_W]    = ch_tag[i];
    end
    g = (exp == -2) ? model_grant(v) : exp;
    if (r) g = -1;
    @(negedge clk);
    check("src_ready", 64'(bus.src_ready), (g >= 0) ? 64'(6'b1 << g) : 64'd0);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: queue empty, expected an entry");
    end else begin
      e = sb_q.pop_front();
      check("cdb_valid", 64'(bus.cdb_valid), 64'(e.valid));
      check("cdb_data",  64'(bus.cdb_data),  64'(e.data));
      check("cdb_tag",   64'(bus.cdb_tag),   64'(e.tag));
      check("cdb_src",   64'(bus.cdb_src),   64'(e.src));
    end
    check("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
    if (g >= 0) sb_q.push_back('{1'b1, ch_data[g], ch_tag[g], SRC_W'(g)});
    else        sb_q.push_back('{1'b0, '0, '0, '0});
    @(posedge clk);
    if (r) begin
      m_stall = 0;
      m_ptr   = 0;
    end else begin
      if ($countones(v) > 1 && m_stall < 65535) m_stall++;
      if (g >= 0) m_ptr = (g + 1) % NUM_SRC;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) ch_data[i] = 32'hC0DE_0000 + 32'(i);
    ch_data[2] = 32'hDEAD_BEEF;
    ch_tag[0] = 4'h0;  // tag 0 is broadcast like any other
    ch_tag[1] = 4'h1;
    ch_tag[2] = 4'h5;
    ch_tag[3] = 4'h3;
    ch_tag[4] = 4'h4;
    ch_tag[5] = 4'h6;

    //          rst   valid       rr  fp
    vecs[0]  = '{1'b1, 6'b000000, -1, -1};  // reset state
    vecs[1]  = '{1'b0, 6'b000100,  2,  2};  // single request ch2
    vecs[2]  = '{1'b0, 6'b000000, -1, -1};
    vecs[3]  = '{1'b1, 6'b100011, -1, -1};  // no accept during reset
    vecs[4]  = '{1'b0, 6'b100011,  0,  0};  // fairness 0,1,5 from reset
    vecs[5]  = '{1'b0, 6'b100011,  1,  0};
    vecs[6]  = '{1'b0, 6'b100011,  5,  0};
    vecs[7]  = '{1'b0, 6'b100011,  0,  0};
    vecs[8]  = '{1'b0, 6'b100011,  1,  0};
    vecs[9]  = '{1'b0, 6'b100011,  5,  0};
    vecs[10] = '{1'b0, 6'b010000,  4,  4};  // last grant ch4 -> ptr 5
    vecs[11] = '{1'b0, 6'b100001,  5,  0};  // wrap: 5 then 0
    vecs[12] = '{1'b0, 6'b000001,  0,  0};
    vecs[13] = '{1'b0, 6'b000011,  1,  0};  // ptr now 1
    vecs[14] = '{1'b0, 6'b001001,  3,  0};  // ch0 vs ch3
    vecs[15] = '{1'b0, 6'b001001,  0,  0};
    vecs[16] = '{1'b0, 6'b000000, -1, -1};  // ptr holds
    vecs[17] = '{1'b0, 6'b000001,  0,  0};  // tag 0 broadcast
    vecs[18] = '{1'b0, 6'b111111,  1,  0};
    vecs[19] = '{1'b0, 6'b000100,  2,  2};  // accept ch2 ...
    vecs[20] = '{1'b1, 6'b000100, -1, -1};  // ... then reset discards it
    vecs[21] = '{1'b0, 6'b001100,  2,  2};  // ptr back at 0
    vecs[22] = '{1'b0, 6'b000000, -1, -1};

    rst           = 1'b1;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_tag   = '0;
    @(posedge clk);
    #1;
    m_ptr   = 0;
    m_stall = 0;
    sb_q.push_back('{1'b0, '0, '0, '0});

    for (int i = 0; i < 23; i++) begin
`ifdef CDB_RR_EN
      step(vecs[i].rst, vecs[i].valid, vecs[i].exp_rr);
`else
      step(vecs[i].rst, vecs[i].valid, vecs[i].exp_fp);
`endif
    end

    // Saturation: 70000 fully contended cycles.
    for (int i = 0; i < 70000; i++) step(1'b0, 6'b111111, -2);
    check("stall_sat", 64'(bus.stall_cnt), 64'hFFFF);
    for (int i = 0; i < 3; i++) step(1'b0, 6'b100001, -2);
    check("stall_hold", 64'(bus.stall_cnt), 64'hFFFF);
    step(1'b0, 6'b000000, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 6: number of producer channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 32: broadcast data width.
REQ-003 SHALL have parameter TAG_W, default 4: reservation-station tag width; tag 0 is reserved for "no producer".
REQ-004 SHALL have port clk, input, 1: single clock; every flop updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port src_valid, input, NUM_SRC: bit i set means channel i holds a result.
REQ-007 SHALL have port src_data, input, NUM_SRC*DATA_W: channel i data occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port src_tag, input, NUM_SRC*TAG_W: channel i tag occupies bits [i*TAG_W +: TAG_W].
REQ-009 SHALL have port src_ready, output, NUM_SRC: one-hot grant; channel i's result is accepted in a cycle where src_valid[i] and src_ready[i] are both 1.
REQ-010 SHALL have port cdb_valid, output, 1: registered broadcast-valid flag.
REQ-011 SHALL have port cdb_data, output, DATA_W: registered broadcast data.
REQ-012 SHALL have port cdb_tag, output, TAG_W: registered broadcast tag.
REQ-013 SHALL have port cdb_src, output, $clog2(NUM_SRC): registered index of the channel that won.
REQ-014 SHALL have port stall_cnt, output, 16: saturating count of cycles in which at least one valid channel was not granted.

Function
REQ-015 SHALL grant at most one channel per cycle; src_ready SHALL be combinational from src_valid and the arbitration state, and SHALL be 0 for every non-valid channel.
REQ-016 SHALL grant whenever any src_valid bit is set; there is no idle cycle while requests are pending.
REQ-017 SHALL present the granted channel's data, tag and index on cdb_data, cdb_tag and cdb_src, with cdb_valid=1, exactly one cycle after the accept (latency 1).
REQ-018 SHALL drive cdb_valid=0, cdb_data=0, cdb_tag=0 and cdb_src=0 in any cycle following a cycle with no grant.
REQ-019 SHALL have each source hold src_valid, data and tag stable until accepted; the arbiter SHALL NOT buffer more than the single output register.
REQ-020 SHALL keep a round-robin pointer rr_ptr; each grant SHALL search channels rr_ptr, rr_ptr+1, ... modulo NUM_SRC and pick the first valid one.
REQ-021 SHALL set rr_ptr to (granted index + 1) mod NUM_SRC after each grant, wrapping from NUM_SRC-1 to 0; rr_ptr SHALL hold its value in cycles with no grant.
REQ-022 SHALL guarantee that a continuously valid channel is granted within NUM_SRC cycles.
REQ-023 SHALL increment stall_cnt by 1 in a cycle where popcount(src_valid) > 1, and SHALL hold it at 16'hFFFF once it reaches that value.
REQ-024 SHALL arbitrate and broadcast a request with tag 0 like any other request; filtering tag 0 is the consumers' responsibility.

Reset
REQ-025 SHALL, with rst=1 at a rising edge, clear cdb_valid, cdb_data, cdb_tag, cdb_src, stall_cnt and rr_ptr to 0.
REQ-026 SHALL force src_ready to all zeros while rst=1, so no result is accepted during reset.
REQ-027 SHALL discard the pending broadcast when reset is asserted in the cycle after an accept; cdb_valid SHALL be 0 on the following cycle.

Configuration
REQ-028 SHALL implement round-robin arbitration per REQ-020..REQ-022 when macro CDB_RR_EN is defined.
REQ-029 SHALL, when CDB_RR_EN is not defined, use fixed priority with the lowest valid index winning; rr_ptr is then absent and REQ-022 is waived.

Verification
REQ-030 SHALL check a single request: NUM_SRC=6, src_valid=6'b000100, tag=4'h5, data=32'hDEADBEEF -> src_ready=6'b000100 in the same cycle; next cycle cdb_valid=1, tag=5, data=DEADBEEF, cdb_src=2.
REQ-031 SHALL check fairness with CDB_RR_EN defined: channels 0, 1 and 5 held valid for 6 cycles from reset -> grants in order 0, 1, 5, 0, 1, 5; stall_cnt=6 after the 6 cycles.
REQ-032 SHALL check fixed priority with CDB_RR_EN undefined: channels 0 and 3 held valid -> channel 0 granted every cycle and channel 3 never granted while channel 0 is valid.
REQ-033 SHALL check wrap-around: rr_ptr=5 (last grant at channel 4), valid=6'b100001 -> grant channel 5, then channel 0; rr_ptr=1 afterwards.
REQ-034 SHALL check reset mid-operation: accept on channel 2, then rst=1 in the next cycle -> cdb_valid=0, stall_cnt=0 and rr_ptr=0 after the edge; src_ready=0 while rst=1.
REQ-035 SHALL check saturation: force 70000 contended cycles -> stall_cnt=16'hFFFF and holds there.
